pll_retune_sequencer: RTL

- Upstream control stage for the IF synthesizer PLL.
- Accepts a frequency word and strobe from the tuning interface, then validates the word.
- Serialises the M and C0 counter values into the PLL reconfiguration controller, triggers reconfiguration, and supervises lock.
- Recovers from lock failure with timeouts, PLL reset and bounded retries; reports ready, locked and error status to the rest of the radio.

---
 rtl/pll_retune_sequencer_if.sv | 40 ++++
 rtl/pll_retune_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_retune_sequencer_if.sv
// ---------------------------------------------------------------------------
// pll_retune_sequencer_if
//
// Bus between the retune sequencer and the PLL reconfiguration controller.
//   counter_type  : counter select (1 = M, 4 = C0)
//   counter_param : parameter select (0 high, 1 low, 4 bypass, 5 odd)
//   data_in       : parameter value, zero-extended to 9 bits
//   write_param   : one-cycle parameter write strobe
//   reconfig      : one-cycle "apply new configuration" strobe
//   cfg_busy      : controller busy, returned by the controller
//
// modport master : sequencer side (drives the command signals)
// modport slave  : reconfiguration controller side (drives cfg_busy)
// ---------------------------------------------------------------------------
interface pll_retune_sequencer_if;
    logic [3:0] counter_type;
    logic [2:0] counter_param;
    logic [8:0] data_in;
    logic       write_param;
    logic       reconfig;
    logic       cfg_busy;

    modport master (
        output counter_type,
        output counter_param,
        output data_in,
        output write_param,
        output reconfig,
        input  cfg_busy
    );

    modport slave (
        input  counter_type,
        input  counter_param,
        input  data_in,
        input  write_param,
        input  reconfig,
        output cfg_busy
    );
endinterface

// File: rtl/pll_retune_sequencer.sv
// ---------------------------------------------------------------------------
// pll_retune_sequencer
//
// Takes a frequency word from the tuning interface, validates it, writes the
// M and C0 counter settings into the PLL reconfiguration controller, pulses
// reconfig and then supervises lock. Lock failures are retried by pulsing
// the PLL reset; after MAX_RETRY retries the sticky error flag is raised.
//
// Ports
//   clk           : system clock
//   reset         : synchronous, active-high reset
//   freq_word     : [15:8] M multiply value, [7:0] C0 divide value
//   freq_strobe   : one-cycle retune request
//   pll_locked    : PLL lock indicator
//   pll_areset_in : PLL reset request (ARESET_CYCLES wide)
//   ready         : idle with nothing queued
//   locked_out    : last retune succeeded and the PLL is still locked
//   error         : sticky failure flag, cleared by the next accepted request
//   cfg           : reconfiguration controller bus (master side)
// ---------------------------------------------------------------------------
module pll_retune_sequencer #(
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int CFG_TIMEOUT   = 4095,
    parameter int ARESET_CYCLES = 16,
    parameter int MAX_RETRY     = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [15:0]                   freq_word,
    input  logic                          freq_strobe,
    input  logic                          pll_locked,
    output logic                          pll_areset_in,
    output logic                          ready,
    output logic                          locked_out,
    output logic                          error,
    pll_retune_sequencer_if.master        cfg
);

    localparam int TMAX_A  = (LOCK_TIMEOUT > CFG_TIMEOUT) ? LOCK_TIMEOUT : CFG_TIMEOUT;
    localparam int TMAX    = (TMAX_A > ARESET_CYCLES) ? TMAX_A : ARESET_CYCLES;
    localparam int TIMER_W = $clog2(TMAX + 1);
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_WRITE,
        ST_WAIT_WR,
        ST_RECONFIG,
        ST_WAIT_CFG,
        ST_WAIT_LOCK,
        ST_RESET_PLL
    } state_t;

    state_t               state_reg, state_next;
    logic [15:0]          work_reg, work_next;
    logic [15:0]          pend_word_reg, pend_word_next;
    logic                 pend_reg, pend_next;
    logic [2:0]           idx_reg, idx_next;
    logic [TIMER_W-1:0]   timer_reg, timer_next;
    logic [RETRY_W-1:0]   retry_reg, retry_next;
    logic                 lock_seen_reg, lock_seen_next;
    logic                 locked_reg, locked_next;
    logic                 error_reg, error_next;
    logic                 ready_int;

    // Parameter value for one field of a counter value d.
    function automatic logic [8:0] decode_field(input logic [7:0] d, input logic [1:0] field);
        logic [8:0] result;
        case (field)
            2'd0:    result = ({1'b0, d} + 9'd1) >> 1;   // high = ceil(d/2)
            2'd1:    result = {1'b0, d} >> 1;            // low  = floor(d/2)
            2'd2:    result = {8'd0, (d == 8'd1)};       // bypass
            default: result = {8'd0, d[0]};              // odd mode
        endcase
        return result;
    endfunction

    function automatic logic [2:0] param_code(input logic [1:0] field);
        logic [2:0] code;
        case (field)
            2'd0:    code = 3'd0;
            2'd1:    code = 3'd1;
            2'd2:    code = 3'd4;
            default: code = 3'd5;
        endcase
        return code;
    endfunction

    // Table of the eight writes: entries 0..3 address M, 4..7 address C0.
    logic [3:0] entry_type  [8];
    logic [2:0] entry_param [8];
    logic [8:0] entry_data  [8];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_entry
            localparam logic [1:0] FIELD = 2'(gi % 4);
            localparam bit         IS_C0 = (gi >= 4);
            assign entry_type[gi]  = IS_C0 ? 4'd4 : 4'd1;
            assign entry_param[gi] = param_code(FIELD);
            assign entry_data[gi]  = decode_field(IS_C0 ? work_reg[7:0] : work_reg[15:8], FIELD);
        end
    endgenerate

    // A strobe is queued whenever the block is not ready, including the last
    // cycle of a sequence that is about to return to idle.
    assign ready_int = (state_reg == ST_IDLE) && !pend_reg;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            work_reg      <= '0;
            pend_word_reg <= '0;
            pend_reg      <= 1'b0;
            idx_reg       <= '0;
            timer_reg     <= '0;
            retry_reg     <= '0;
            lock_seen_reg <= 1'b0;
            locked_reg    <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            work_reg      <= work_next;
            pend_word_reg <= pend_word_next;
            pend_reg      <= pend_next;
            idx_reg       <= idx_next;
            timer_reg     <= timer_next;
            retry_reg     <= retry_next;
            lock_seen_reg <= lock_seen_next;
            locked_reg    <= locked_next;
            error_reg     <= error_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        work_next      = work_reg;
        pend_word_next = pend_word_reg;
        pend_next      = pend_reg;
        idx_next       = idx_reg;
        timer_next     = timer_reg;
        retry_next     = retry_reg;
        lock_seen_next = lock_seen_reg;
        locked_next    = locked_reg;
        error_next     = error_reg;

        if (freq_strobe && !ready_int) begin
            pend_word_next = freq_word;
            pend_next      = 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (!pll_locked) begin
                    locked_next = 1'b0;
                end
                // A strobe arriving while a queued request is being taken is
                // the newer one, so it wins over the queued word.
                if (pend_reg || freq_strobe) begin
                    work_next   = freq_strobe ? freq_word : pend_word_reg;
                    pend_next   = 1'b0;
                    locked_next = 1'b0;
                    error_next  = 1'b0;
                    retry_next  = '0;
                    state_next  = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (work_reg[15:8] == 8'd0 || work_reg[7:0] == 8'd0) begin
                    error_next = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    idx_next   = '0;
                    state_next = ST_WRITE;
                end
            end

            ST_WRITE: begin
                timer_next = '0;
                state_next = ST_WAIT_WR;
            end

            ST_WAIT_WR: begin
                // timer_reg == 0 is the cycle right after the pulse, where the
                // controller may not have raised busy yet.
                if (timer_reg != '0 && !cfg.cfg_busy) begin
                    if (idx_reg == 3'd7) begin
                        state_next = ST_RECONFIG;
                    end else begin
                        idx_next   = idx_reg + 3'd1;
                        state_next = ST_WRITE;
                    end
                end else if (timer_reg == TIMER_W'(CFG_TIMEOUT)) begin
                    error_next = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end

            ST_RECONFIG: begin
                timer_next = '0;
                state_next = ST_WAIT_CFG;
            end

            ST_WAIT_CFG: begin
                if (timer_reg != '0 && !cfg.cfg_busy) begin
                    timer_next     = '0;
                    lock_seen_next = 1'b0;
                    state_next     = ST_WAIT_LOCK;
                end else if (timer_reg == TIMER_W'(CFG_TIMEOUT)) begin
                    error_next = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end

            ST_WAIT_LOCK: begin
                if (pll_locked && lock_seen_reg) begin
                    locked_next = 1'b1;
                    state_next  = ST_IDLE;
                end else if (timer_reg == TIMER_W'(LOCK_TIMEOUT - 1)) begin
                    if (retry_reg < RETRY_W'(MAX_RETRY)) begin
                        retry_next = retry_reg + 1'b1;
                        timer_next = '0;
                        state_next = ST_RESET_PLL;
                    end else begin
                        error_next = 1'b1;
                        state_next = ST_IDLE;
                    end
                end else begin
                    timer_next     = timer_reg + 1'b1;
                    lock_seen_next = pll_locked;
                end
            end

            ST_RESET_PLL: begin
                // Counter settings live in the PLL and survive areset, so the
                // sequence resumes at lock supervision rather than rewriting.
                if (timer_reg == TIMER_W'(ARESET_CYCLES - 1)) begin
                    timer_next     = '0;
                    lock_seen_next = 1'b0;
                    state_next     = ST_WAIT_LOCK;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        ready             = ready_int;
        locked_out        = locked_reg;
        error             = error_reg;
        pll_areset_in     = (state_reg == ST_RESET_PLL);
        cfg.write_param   = (state_reg == ST_WRITE);
        cfg.reconfig      = (state_reg == ST_RECONFIG);
        cfg.counter_type  = 4'd0;
        cfg.counter_param = 3'd0;
        cfg.data_in       = 9'd0;
        // Hold the write fields from the pulse until busy is seen low.
        if (state_reg == ST_WRITE || state_reg == ST_WAIT_WR) begin
            cfg.counter_type  = entry_type[idx_reg];
            cfg.counter_param = entry_param[idx_reg];
            cfg.data_in       = entry_data[idx_reg];
        end
    end

endmodule
